// File: rtl/game_pkg.sv
// Shared constants, state encoding and motion-rate helpers for the cube jump
// controller. Optional feature macro used by the controller: JUMP_DOUBLE_EN.
package game_pkg;

  typedef enum logic [1:0] {
    ST_STAND = 2'd0,
    ST_RISE  = 2'd1,
    ST_FALL  = 2'd2,
    ST_DEAD  = 2'd3
  } state_e;

  localparam logic [9:0]  CUBE_X     = 10'd120;
  localparam logic [9:0]  CUBE_W     = 10'd20;
  localparam logic [9:0]  CUBE_H     = 10'd40;
  localparam logic [9:0]  FLOOR_W    = 10'd100;
  localparam logic [9:0]  CEIL_Y     = 10'd100;
  localparam logic [10:0] SCREEN_H   = 11'd480;
  localparam logic [8:0]  RISE_END   = 9'd320;
  localparam logic [9:0]  CUBE_Y_RST = 10'd290;
  localparam logic [7:0]  FALL_MAX   = 8'd255;

  // Rising slows down in four bands of 80 ticks: every tick, 1/2, 1/4, 1/8.
  function automatic logic rise_step(input logic [8:0] tg);
    logic step;
    step = 1'b0;
    if (tg == 9'd0)        step = 1'b0;
    else if (tg < 9'd80)   step = 1'b1;
    else if (tg < 9'd160)  step = ~tg[0];
    else if (tg < 9'd240)  step = (tg[1:0] == 2'd0);
    else if (tg < 9'd320)  step = (tg[2:0] == 3'd0);
    return step;
  endfunction

  // Falling speeds up: 1/4 rate, then 1/2 rate, then every tick.
  function automatic logic fall_step(input logic [7:0] fc);
    logic step;
    if (fc < 8'd80)       step = (fc[1:0] == 2'd0);
    else if (fc < 8'd160) step = ~fc[0];
    else                  step = 1'b1;
    return step;
  endfunction

endpackage

// File: rtl/cube_jump_ctrl_if.sv
// Game-side bus of the cube jump controller: step strobe, button, floor table
// in, cube position and status out.
//
// Protocol: tick is a one-cycle strobe sampled on posedge clk; every state
// update happens on a cycle where tick=1 and nothing moves otherwise. Floor
// inputs and jump_btn are levels sampled on the same edge as tick. Outputs are
// registered state (plus flags decoded from it) and are valid every cycle.
interface cube_jump_ctrl_if;
  logic       tick;
  logic       jump_btn;
  logic [9:0] floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3;
  logic [9:0] floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3;
  logic [3:0] enable;
  logic [9:0] cube_y;
  logic [8:0] time_gap;
  logic       hit_ceiling;
  logic       on_floor;
  logic       game_over;

  modport master (
    output tick, jump_btn, enable,
    output floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3,
    output floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3,
    input  cube_y, time_gap, hit_ceiling, on_floor, game_over
  );

  modport slave (
    input  tick, jump_btn, enable,
    input  floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3,
    input  floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3,
    output cube_y, time_gap, hit_ceiling, on_floor, game_over
  );
endinterface

// File: rtl/cube_floor_hit.sv
// Combinational support test of the cube against one floor: floor enabled,
// horizontal overlap, and cube bottom exactly on the floor top row.
module cube_floor_hit
  import game_pkg::*;
(
  input  logic       i_en,
  input  logic [9:0] i_floor_x,
  input  logic [9:0] i_floor_y,
  input  logic [9:0] i_cube_y,
  output logic       o_hit
);
  logic [10:0] w_x;
  logic [10:0] w_cube_bot;
  logic        w_overlap;

  assign w_x        = {1'b0, i_floor_x};
  assign w_cube_bot = {1'b0, i_cube_y} + {1'b0, CUBE_H};

  // x_i - FLOOR_W < CUBE_X + CUBE_W rewritten without subtraction so a floor
  // near x=0 cannot wrap; x_i > CUBE_X is the other overlap edge.
  assign w_overlap = (w_x < ({1'b0, CUBE_X} + {1'b0, CUBE_W} + {1'b0, FLOOR_W}))
                  && (w_x > {1'b0, CUBE_X});

  // Support needs all three conditions at once.
  always_comb begin
    o_hit = i_en && w_overlap && (w_cube_bot == {1'b0, i_floor_y});
  end
endmodule

// File: rtl/cube_jump_ctrl.sv
// Cube jump controller: STAND/RISE/FALL/DEAD motion FSM advanced by tick.
// Macro JUMP_DOUBLE_EN enables one extra jump while falling, re-armed on
// landing; without it jump_btn is only honoured while standing.
module cube_jump_ctrl
  import game_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  cube_jump_ctrl_if.slave   bus,
  output logic [1:0]        o_dbg_state
);
  localparam logic [1:0] S_STAND = ST_STAND;
  localparam logic [1:0] S_RISE  = ST_RISE;
  localparam logic [1:0] S_FALL  = ST_FALL;
  localparam logic [1:0] S_DEAD  = ST_DEAD;

  logic [1:0] r_state;
  logic [9:0] r_cube_y;
  logic [8:0] r_time_gap;
  logic [7:0] r_fall_cnt;
`ifdef JUMP_DOUBLE_EN
  logic       r_dbl_avail;
`endif

  logic [9:0] w_fx [4];
  logic [9:0] w_fy [4];
  logic [3:0] w_hit;
  logic       w_supp;
  logic       w_dead;
  logic [9:0] w_floor_y;

  assign w_fx[0] = bus.floor_pos_x0;
  assign w_fx[1] = bus.floor_pos_x1;
  assign w_fx[2] = bus.floor_pos_x2;
  assign w_fx[3] = bus.floor_pos_x3;
  assign w_fy[0] = bus.floor_pos_y0;
  assign w_fy[1] = bus.floor_pos_y1;
  assign w_fy[2] = bus.floor_pos_y2;
  assign w_fy[3] = bus.floor_pos_y3;

  for (genvar g = 0; g < 4; g++) begin : g_hit
    cube_floor_hit u_hit (
      .i_en      (bus.enable[g]),
      .i_floor_x (w_fx[g]),
      .i_floor_y (w_fy[g]),
      .i_cube_y  (r_cube_y),
      .o_hit     (w_hit[g])
    );
  end

  assign w_supp = |w_hit;
  assign w_dead = ({1'b0, r_cube_y} + {1'b0, CUBE_H}) >= SCREEN_H;

  // Top row of the lowest-index supporting floor; defaults to the current
  // cube bottom so an unsupported cube keeps its row.
  always_comb begin
    w_floor_y = r_cube_y + CUBE_H;
    for (int i = 3; i >= 0; i--) begin
      if (w_hit[i]) w_floor_y = w_fy[i];
    end
  end

  // Motion FSM; every update is gated by the game-step strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_STAND;
      r_cube_y   <= CUBE_Y_RST;
      r_time_gap <= 9'd0;
      r_fall_cnt <= 8'd0;
`ifdef JUMP_DOUBLE_EN
      r_dbl_avail <= 1'b1;
`endif
    end else if (bus.tick) begin
      case (r_state)
        S_STAND: begin
          if (w_dead) begin
            r_state <= S_DEAD;
          end else if (bus.jump_btn) begin
            r_state    <= S_RISE;
            r_time_gap <= 9'd1;
          end else if (!w_supp) begin
            r_state    <= S_FALL;
            r_fall_cnt <= 8'd0;
          end else begin
            r_cube_y <= w_floor_y - CUBE_H;
          end
        end
        S_RISE: begin
          if (w_dead) begin
            r_state    <= S_DEAD;
            r_time_gap <= 9'd0;
          end else if (r_time_gap == RISE_END) begin
            r_state    <= S_FALL;
            r_time_gap <= 9'd0;
            r_fall_cnt <= 8'd0;
          end else begin
            // Pinned at the ceiling the cube stays put and the floors scroll.
            if (rise_step(r_time_gap) && (r_cube_y > CEIL_Y))
              r_cube_y <= r_cube_y - 10'd1;
            r_time_gap <= r_time_gap + 9'd1;
          end
        end
        S_FALL: begin
          if (w_dead) begin
            r_state <= S_DEAD;
          end else if (w_supp) begin
            r_state <= S_STAND;
`ifdef JUMP_DOUBLE_EN
            r_dbl_avail <= 1'b1;
          end else if (bus.jump_btn && r_dbl_avail) begin
            r_state     <= S_RISE;
            r_time_gap  <= 9'd1;
            r_dbl_avail <= 1'b0;
`endif
          end else begin
            if (fall_step(r_fall_cnt)) r_cube_y <= r_cube_y + 10'd1;
            if (r_fall_cnt != FALL_MAX) r_fall_cnt <= r_fall_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_DEAD;
        end
      endcase
    end
  end

  assign bus.cube_y      = r_cube_y;
  assign bus.time_gap    = r_time_gap;
  assign bus.hit_ceiling = (r_state == S_RISE) && (r_cube_y == CEIL_Y);
  assign bus.on_floor    = (r_state == S_STAND);
  assign bus.game_over   = (r_state == S_DEAD);
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_cube_jump_ctrl.sv
// Directed bench for cube_jump_ctrl (JUMP_DOUBLE_EN selects the double-jump
// scenario instead of the ignored-press scenario).
module tb_cube_jump_ctrl;
  localparam logic [1:0] STAND = 2'd0, RISE = 2'd1, FALL = 2'd2, DEAD = 2'd3;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         errors;
  int         checks;

  cube_jump_ctrl_if bus ();

  cube_jump_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks; all start and end on a negedge
  task automatic run_ticks(input int n);
    if (n > 0) begin
      bus.tick = 1'b1;
      repeat (n) @(negedge clk);
      bus.tick = 1'b0;
    end
  endtask

  task automatic press_jump();
    bus.jump_btn = 1'b1;
    run_ticks(1);
    bus.jump_btn = 1'b0;
  endtask

  task automatic wait_land(input int budget, output int n);
    n = 0;
    bus.tick = 1'b1;
    while (n < budget && !bus.on_floor) begin
      @(negedge clk);
      n++;
    end
    bus.tick = 1'b0;
  endtask

  task automatic set_floors();
    bus.floor_pos_x0 = 10'd150; bus.floor_pos_y0 = 10'd330;
    bus.floor_pos_x1 = 10'd200; bus.floor_pos_y1 = 10'd190;
    bus.floor_pos_x2 = 10'd600; bus.floor_pos_y2 = 10'd330;
    bus.floor_pos_x3 = 10'd50;  bus.floor_pos_y3 = 10'd330;
    bus.enable = 4'b0001;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_floors();
    repeat (2) @(negedge clk);
    checks++; if (bus.cube_y !== 10'd290) begin errors++; $display("FAIL reset_cube_y: got %0d expected 290", bus.cube_y); end
    checks++; if (bus.on_floor !== 1'b1) begin errors++; $display("FAIL reset_on_floor: got %b expected 1", bus.on_floor); end
    checks++; if (bus.time_gap !== 9'd0) begin errors++; $display("FAIL reset_time_gap: got %0d expected 0", bus.time_gap); end
    checks++; if (bus.hit_ceiling !== 1'b0 || bus.game_over !== 1'b0) begin errors++; $display("FAIL reset_flags: got hit=%b over=%b expected 0 0", bus.hit_ceiling, bus.game_over); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_no_tick();
    bus.jump_btn = 1'b1;
    repeat (3) @(negedge clk);
    bus.jump_btn = 1'b0;
    checks++; if (dbg_state !== STAND || bus.time_gap !== 9'd0) begin errors++; $display("FAIL no_tick_hold: got state=%0d tg=%0d expected 0 0", dbg_state, bus.time_gap); end
    run_ticks(2);
    checks++; if (bus.cube_y !== 10'd290 || bus.on_floor !== 1'b1) begin errors++; $display("FAIL stand_supported: got y=%0d on=%b expected 290 1", bus.cube_y, bus.on_floor); end
  endtask

  task automatic test_rise();
    press_jump();
    checks++; if (dbg_state !== RISE || bus.time_gap !== 9'd1 || bus.cube_y !== 10'd290) begin errors++; $display("FAIL jump_start: got st=%0d tg=%0d y=%0d expected 1 1 290", dbg_state, bus.time_gap, bus.cube_y); end
    run_ticks(79);
    checks++; if (bus.cube_y !== 10'd211 || bus.time_gap !== 9'd80) begin errors++; $display("FAIL rise_band1: got y=%0d tg=%0d expected 211 80", bus.cube_y, bus.time_gap); end
    run_ticks(80);
    checks++; if (bus.cube_y !== 10'd171 || bus.time_gap !== 9'd160) begin errors++; $display("FAIL rise_band2: got y=%0d tg=%0d expected 171 160", bus.cube_y, bus.time_gap); end
    run_ticks(80);
    checks++; if (bus.cube_y !== 10'd151 || bus.time_gap !== 9'd240) begin errors++; $display("FAIL rise_band3: got y=%0d tg=%0d expected 151 240", bus.cube_y, bus.time_gap); end
    run_ticks(80);
    checks++; if (bus.cube_y !== 10'd141 || bus.time_gap !== 9'd320 || dbg_state !== RISE) begin errors++; $display("FAIL rise_end: got y=%0d tg=%0d st=%0d expected 141 320 1", bus.cube_y, bus.time_gap, dbg_state); end
    run_ticks(1);
    checks++; if (dbg_state !== FALL || bus.time_gap !== 9'd0 || bus.cube_y !== 10'd141) begin errors++; $display("FAIL rise_to_fall: got st=%0d tg=%0d y=%0d expected 2 0 141", dbg_state, bus.time_gap, bus.cube_y); end
  endtask

  task automatic test_fall_land();
    int n;
    run_ticks(160);
    checks++; if (bus.cube_y !== 10'd201 || dbg_state !== FALL) begin errors++; $display("FAIL fall_rate: got y=%0d st=%0d expected 201 2", bus.cube_y, dbg_state); end
    wait_land(200, n);
    checks++; if (bus.on_floor !== 1'b1 || bus.cube_y !== 10'd290 || bus.time_gap !== 9'd0) begin errors++; $display("FAIL land_290: got on=%b y=%0d tg=%0d expected 1 290 0", bus.on_floor, bus.cube_y, bus.time_gap); end
    checks++; if (n !== 90) begin errors++; $display("FAIL land_290_ticks: got %0d expected 90", n); end
  endtask

  task automatic test_ceiling();
    int n;
    bus.enable = 4'b0011;
    press_jump();
    run_ticks(320);
    checks++; if (dbg_state !== FALL || bus.cube_y !== 10'd141) begin errors++; $display("FAIL second_jump_fall: got st=%0d y=%0d expected 2 141", dbg_state, bus.cube_y); end
    wait_land(60, n);
    checks++; if (bus.on_floor !== 1'b1 || bus.cube_y !== 10'd150 || n !== 34) begin errors++; $display("FAIL land_150: got on=%b y=%0d ticks=%0d expected 1 150 34", bus.on_floor, bus.cube_y, n); end
    press_jump();
    run_ticks(49);
    checks++; if (bus.cube_y !== 10'd101 || bus.time_gap !== 9'd50 || bus.hit_ceiling !== 1'b0) begin errors++; $display("FAIL pre_ceiling: got y=%0d tg=%0d hit=%b expected 101 50 0", bus.cube_y, bus.time_gap, bus.hit_ceiling); end
    run_ticks(1);
    checks++; if (bus.cube_y !== 10'd100 || bus.time_gap !== 9'd51 || bus.hit_ceiling !== 1'b1) begin errors++; $display("FAIL at_ceiling: got y=%0d tg=%0d hit=%b expected 100 51 1", bus.cube_y, bus.time_gap, bus.hit_ceiling); end
    run_ticks(269);
    checks++; if (bus.cube_y !== 10'd100 || bus.time_gap !== 9'd320 || bus.hit_ceiling !== 1'b1) begin errors++; $display("FAIL ceiling_hold: got y=%0d tg=%0d hit=%b expected 100 320 1", bus.cube_y, bus.time_gap, bus.hit_ceiling); end
    run_ticks(1);
    checks++; if (dbg_state !== FALL || bus.hit_ceiling !== 1'b0 || bus.cube_y !== 10'd100) begin errors++; $display("FAIL ceiling_release: got st=%0d hit=%b y=%0d expected 2 0 100", dbg_state, bus.hit_ceiling, bus.cube_y); end
    bus.enable = 4'b0001;
  endtask

`ifdef JUMP_DOUBLE_EN
  task automatic test_double_jump();
    int n;
    press_jump();
    checks++; if (dbg_state !== RISE || bus.time_gap !== 9'd1 || bus.cube_y !== 10'd100) begin errors++; $display("FAIL double_jump: got st=%0d tg=%0d y=%0d expected 1 1 100", dbg_state, bus.time_gap, bus.cube_y); end
    run_ticks(320);
    press_jump();
    checks++; if (dbg_state !== FALL || bus.cube_y !== 10'd101) begin errors++; $display("FAIL third_press_ignored: got st=%0d y=%0d expected 2 101", dbg_state, bus.cube_y); end
    wait_land(400, n);
    checks++; if (bus.on_floor !== 1'b1 || bus.cube_y !== 10'd290 || n !== 290) begin errors++; $display("FAIL land_after_double: got on=%b y=%0d ticks=%0d expected 1 290 290", bus.on_floor, bus.cube_y, n); end
    press_jump();
    run_ticks(320);
    press_jump();
    checks++; if (dbg_state !== RISE || bus.time_gap !== 9'd1) begin errors++; $display("FAIL double_rearmed: got st=%0d tg=%0d expected 1 1", dbg_state, bus.time_gap); end
  endtask
`else
  task automatic test_no_double_jump();
    int n;
    press_jump();
    checks++; if (dbg_state !== FALL || bus.time_gap !== 9'd0 || bus.cube_y !== 10'd101) begin errors++; $display("FAIL fall_press_ignored: got st=%0d tg=%0d y=%0d expected 2 0 101", dbg_state, bus.time_gap, bus.cube_y); end
    wait_land(400, n);
    checks++; if (bus.on_floor !== 1'b1 || bus.cube_y !== 10'd290 || n !== 290) begin errors++; $display("FAIL land_from_ceiling: got on=%b y=%0d ticks=%0d expected 1 290 290", bus.on_floor, bus.cube_y, n); end
  endtask
`endif

  task automatic test_dead();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    set_floors();
    bus.enable = 4'b0000;
    run_ticks(1);
    checks++; if (dbg_state !== FALL || bus.cube_y !== 10'd290 || bus.on_floor !== 1'b0) begin errors++; $display("FAIL support_lost: got st=%0d y=%0d on=%b expected 2 290 0", dbg_state, bus.cube_y, bus.on_floor); end
    run_ticks(160);
    checks++; if (bus.cube_y !== 10'd350) begin errors++; $display("FAIL fall_from_stand: got y=%0d expected 350", bus.cube_y); end
    run_ticks(90);
    checks++; if (bus.cube_y !== 10'd440) begin errors++; $display("FAIL reach_bottom: got y=%0d expected 440", bus.cube_y); end
    run_ticks(1);
    checks++; if (bus.game_over !== 1'b1 || bus.cube_y !== 10'd440 || bus.on_floor !== 1'b0) begin errors++; $display("FAIL game_over: got over=%b y=%0d on=%b expected 1 440 0", bus.game_over, bus.cube_y, bus.on_floor); end
    bus.enable = 4'b1111;
    bus.jump_btn = 1'b1;
    run_ticks(5);
    bus.jump_btn = 1'b0;
    checks++; if (bus.game_over !== 1'b1 || bus.cube_y !== 10'd440 || bus.time_gap !== 9'd0) begin errors++; $display("FAIL dead_hold: got over=%b y=%0d tg=%0d expected 1 440 0", bus.game_over, bus.cube_y, bus.time_gap); end
  endtask

  task automatic test_jump_priority_and_abort();
    rst = 1'b0;
    #1;
    checks++; if (bus.game_over !== 1'b0 || bus.cube_y !== 10'd290) begin errors++; $display("FAIL reset_from_dead: got over=%b y=%0d expected 0 290", bus.game_over, bus.cube_y); end
    @(negedge clk);
    rst = 1'b1;
    bus.enable = 4'b0000;
    press_jump();
    checks++; if (dbg_state !== RISE || bus.time_gap !== 9'd1) begin errors++; $display("FAIL jump_priority: got st=%0d tg=%0d expected 1 1", dbg_state, bus.time_gap); end
    run_ticks(10);
    checks++; if (bus.cube_y !== 10'd280 || bus.time_gap !== 9'd11) begin errors++; $display("FAIL short_rise: got y=%0d tg=%0d expected 280 11", bus.cube_y, bus.time_gap); end
    #2 rst = 1'b0;
    #1;
    checks++; if (dbg_state !== STAND || bus.cube_y !== 10'd290 || bus.time_gap !== 9'd0 || bus.on_floor !== 1'b1) begin errors++; $display("FAIL async_abort: got st=%0d y=%0d tg=%0d on=%b expected 0 290 0 1", dbg_state, bus.cube_y, bus.time_gap, bus.on_floor); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.tick = 1'b0;
    bus.jump_btn = 1'b0;
    test_reset();
    test_no_tick();
    test_rise();
    test_fall_land();
    test_ceiling();
`ifdef JUMP_DOUBLE_EN
    test_double_jump();
`else
    test_no_double_jump();
`endif
    test_dead();
    test_jump_priority_and_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
